// File: rtl/lcd_display_cpu_ocimem_jtag_bridge.sv
// Sysclk-side OCI memory bridge: runs debugger read/write commands against the debug RAM.
// Define OCIMEM_WRITE_VERIFY_EN to read back and compare every write.
module lcd_display_cpu_ocimem_jtag_bridge #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              debugack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WRITE
`ifdef OCIMEM_WRITE_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              err_raise, err_clear;

  // Bits of jdo this block does not decode.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mon_d     = mon_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdy_d     = rdy_q;
    err_raise = 1'b0;
    err_clear = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = ptr_q;

    if (state_q == IDLE) begin
      if (take_action_ocimem_b) begin
        err_raise = take_action_ocimem_a | take_no_action_ocimem_a;
        rdy_d     = 1'b0;
        if (!debugack) begin
          err_raise = 1'b1;
          rdy_d     = 1'b1;
        end else begin
          wdata_d = jdo[34:3];
          state_d = WRITE;
        end
      end else if (take_action_ocimem_a) begin
        // An accepted A clears the sticky error but keeps a same-cycle dropped strobe.
        err_clear = 1'b1;
        err_raise = take_no_action_ocimem_a;
        ptr_d     = jdo[ADDR_W+16:17];
        if (jdo[35]) begin
          rdy_d   = 1'b0;
          state_d = RD_ISSUE;
        end else begin
          rdy_d = 1'b1;
        end
      end else if (take_no_action_ocimem_a) begin
        rdy_d   = 1'b0;
        state_d = RD_ISSUE;
      end
    end else if (take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b) begin
      err_raise = 1'b1;
    end

    case (state_q)
      RD_ISSUE: begin
        ram_rd  = 1'b1;
        cnt_d   = 2'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 2'(RD_LAT - 1)) begin
          mon_d   = ram_rdata;
          ptr_d   = ptr_q + ADDR_W'(1);
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        ram_wr = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
`ifdef OCIMEM_WRITE_VERIFY_EN
        cnt_d   = 2'd0;
        state_d = VERIFY;
`else
        rdy_d   = 1'b1;
        state_d = IDLE;
`endif
      end
`ifdef OCIMEM_WRITE_VERIFY_EN
      VERIFY: begin
        // Pointer already advanced in WRITE; read back the word just written.
        ram_addr = ptr_q - ADDR_W'(1);
        ram_rd   = (cnt_q == 2'd0);
        if (cnt_q == 2'(RD_LAT)) begin
          mon_d     = ram_rdata;
          err_raise = err_raise | (ram_rdata != wdata_q);
          rdy_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`endif
      default: ;
    endcase

    err_d = err_clear ? err_raise : (err_q | err_raise);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != IDLE);
  assign ram_wdata     = wdata_q;

endmodule
